// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// stall counter. Bubbles are inserted on load-use hazards and on flush.
module idex_hazard_stage #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CTRL_W       = 8,
    parameter int unsigned REGWRITE_BIT = 0,
    parameter int unsigned MEMREAD_BIT  = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              hold,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic [4:0]        ifid_rd,
    input  logic              ifid_uses_rt,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    output logic [4:0]        idex_rs,
    output logic [4:0]        idex_rt,
    output logic [4:0]        idex_rd,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [DATA_W-1:0] idex_rdata1,
    output logic [DATA_W-1:0] idex_rdata2,
    output logic [DATA_W-1:0] idex_imm,
    output logic [DATA_W-1:0] idex_pc4,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic haz;
    logic rs_match;
    logic rt_match;

    // Load-use detection: the load in EX writes a register the ID instruction reads.
    // A load to $0 never creates a dependency.
    always_comb begin
        rs_match = (idex_rt == ifid_rs);
        rt_match = ifid_uses_rt && (idex_rt == ifid_rt);
        haz      = idex_ctrl[MEMREAD_BIT] && (idex_rt != 5'd0) && (rs_match || rt_match);
        // flush redirects IF, hold already freezes everything, so neither stalls
        stall    = haz && !flush && !hold;
    end

    // Pipeline register update: reset > flush > hold > hazard bubble > load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_rd     <= '0;
            idex_ctrl   <= '0;
            idex_rdata1 <= '0;
            idex_rdata2 <= '0;
            idex_imm    <= '0;
            idex_pc4    <= '0;
            stall_count <= '0;
        end else if (flush || (haz && !hold)) begin
            // Bubble clears specifiers too, so no false forwarding or repeat hazard
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_rd     <= '0;
            idex_ctrl   <= '0;
            idex_rdata1 <= '0;
            idex_rdata2 <= '0;
            idex_imm    <= '0;
            idex_pc4    <= '0;
            if (!flush && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end else if (!hold) begin
            idex_rs     <= ifid_rs;
            idex_rt     <= ifid_rt;
            idex_rd     <= ifid_rd;
            idex_ctrl   <= id_ctrl;
            idex_rdata1 <= id_rdata1;
            idex_rdata2 <= id_rdata2;
            idex_imm    <= id_imm;
            idex_pc4    <= id_pc4;
        end
    end

    // RegWrite is carried in ctrl for later stages; unused here
    logic unused_regwrite;
    assign unused_regwrite = idex_ctrl[REGWRITE_BIT];

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed self-checking bench for idex_hazard_stage. A second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation cheaply.
module tb_idex_hazard_stage;

    logic        Clk = 1'b0;
    logic        Reset, flush, hold;
    logic [4:0]  ifid_rs, ifid_rt, ifid_rd;
    logic        ifid_uses_rt;
    logic [7:0]  id_ctrl;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;

    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic [7:0]  idex_ctrl;
    logic [31:0] idex_rdata1, idex_rdata2, idex_imm, idex_pc4;
    logic        stall;
    logic [15:0] stall_count;

    logic [4:0]  s_rs, s_rt, s_rd;
    logic [7:0]  s_ctrl;
    logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
    logic        s_stall;
    logic [1:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    idex_hazard_stage dut (
        .Clk(Clk), .Reset(Reset), .flush(flush), .hold(hold),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd), .ifid_uses_rt(ifid_uses_rt),
        .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_pc4(id_pc4),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_ctrl(idex_ctrl),
        .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
        .idex_imm(idex_imm), .idex_pc4(idex_pc4),
        .stall(stall), .stall_count(stall_count)
    );

    idex_hazard_stage #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .flush(flush), .hold(hold),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd), .ifid_uses_rt(ifid_uses_rt),
        .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_pc4(id_pc4),
        .idex_rs(s_rs), .idex_rt(s_rt), .idex_rd(s_rd), .idex_ctrl(s_ctrl),
        .idex_rdata1(s_rdata1), .idex_rdata2(s_rdata2),
        .idex_imm(s_imm), .idex_pc4(s_pc4),
        .stall(s_stall), .stall_count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic uses_rt, input logic [7:0] ctrl,
                          input logic [31:0] d1);
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_rd      = rd;
        ifid_uses_rt = uses_rt;
        id_ctrl      = ctrl;
        id_rdata1    = d1;
        id_rdata2    = d1 ^ 32'hFFFF_0000;
        id_imm       = d1 + 32'd4;
        id_pc4       = d1 + 32'd8;
        #1;
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        set_id(5'd8, 5'd8, 5'd3, 1'b1, 8'h03, 32'h1234_5678);
        step();
        step();
        check("rst_rdata1", idex_rdata1, 32'h0);
        check("rst_ctrl", {24'h0, idex_ctrl}, 32'h0);
        check("rst_rt", {27'h0, idex_rt}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_count", {16'h0, stall_count}, 32'h0);

        // lw $8 enters EX
        Reset = 1'b0;
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h1234_5678);
        check("lw_no_stall", {31'h0, stall}, 32'h0);
        step();
        check("load_rdata1", idex_rdata1, 32'h1234_5678);
        check("load_rdata2", idex_rdata2, 32'hEDCB_5678);
        check("load_pc4", idex_pc4, 32'h1234_5680);
        check("load_rt", {27'h0, idex_rt}, 32'd8);

        // dependent add via rs: one bubble
        set_id(5'd8, 5'd9, 5'd10, 1'b1, 8'h01, 32'hAAAA_0001);
        check("rs_haz_stall", {31'h0, stall}, 32'h1);
        step();
        check("bubble_ctrl", {24'h0, idex_ctrl}, 32'h0);
        check("bubble_rs", {27'h0, idex_rs}, 32'h0);
        check("bubble_count", {16'h0, stall_count}, 32'd1);
        check("after_bubble_stall", {31'h0, stall}, 32'h0);
        step();
        check("add_rs", {27'h0, idex_rs}, 32'd8);
        check("add_rd", {27'h0, idex_rd}, 32'd10);
        check("add_rdata1", idex_rdata1, 32'hAAAA_0001);
        check("add_count", {16'h0, stall_count}, 32'd1);

        // sw reading rt=8 stalls; addi writing rt=8 does not
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h0000_0100);
        check("lw2_no_stall", {31'h0, stall}, 32'h0);
        step();
        set_id(5'd2, 5'd8, 5'd0, 1'b1, 8'h04, 32'h0000_0200);
        check("sw_rt_stall", {31'h0, stall}, 32'h1);
        set_id(5'd2, 5'd8, 5'd0, 1'b0, 8'h01, 32'h0000_0300);
        check("addi_no_stall", {31'h0, stall}, 32'h0);
        step();
        check("addi_loaded", {24'h0, idex_ctrl}, 32'h01);
        check("addi_count", {16'h0, stall_count}, 32'd1);

        // load to $0 never stalls
        set_id(5'd1, 5'd0, 5'd0, 1'b0, 8'h03, 32'h0000_0400);
        step();
        set_id(5'd0, 5'd0, 5'd11, 1'b1, 8'h01, 32'h0000_0500);
        check("lw0_no_stall", {31'h0, stall}, 32'h0);
        step();
        check("lw0_no_bubble", {27'h0, idex_rd}, 32'd11);
        check("lw0_count", {16'h0, stall_count}, 32'd1);

        // flush beats hazard
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h0000_0600);
        step();
        set_id(5'd8, 5'd9, 5'd12, 1'b1, 8'h01, 32'h0000_0700);
        check("pre_flush_stall", {31'h0, stall}, 32'h1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'h0, stall}, 32'h0);
        step();
        flush = 1'b0;
        check("flush_ctrl", {24'h0, idex_ctrl}, 32'h0);
        check("flush_rt", {27'h0, idex_rt}, 32'h0);
        check("flush_count", {16'h0, stall_count}, 32'd1);

        // hold freezes contents and count
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h0000_0055);
        step();
        set_id(5'd8, 5'd9, 5'd13, 1'b1, 8'h01, 32'h0000_0800);
        hold = 1'b1;
        #1;
        check("hold_stall", {31'h0, stall}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rdata1", idex_rdata1, 32'h0000_0055);
            check("hold_ctrl", {24'h0, idex_ctrl}, 32'h03);
            check("hold_count", {16'h0, stall_count}, 32'd1);
        end
        hold = 1'b0;
        #1;
        check("unhold_stall", {31'h0, stall}, 32'h1);
        step();
        check("unhold_count", {16'h0, stall_count}, 32'd2);
        check("sat_inst_count2", {30'h0, s_count}, 32'd2);
        step();
        check("unhold_add_rd", {27'h0, idex_rd}, 32'd13);

        // reset during a stall wins
        set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h0000_0900);
        step();
        set_id(5'd8, 5'd9, 5'd14, 1'b1, 8'h01, 32'h0000_0A00);
        check("pre_rst_stall", {31'h0, stall}, 32'h1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        check("rst_mid_count", {16'h0, stall_count}, 32'd0);
        check("rst_mid_ctrl", {24'h0, idex_ctrl}, 32'h0);
        check("rst_mid_stall", {31'h0, stall}, 32'h0);

        // repeated hazards: 16-bit counter counts, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_id(5'd1, 5'd8, 5'd0, 1'b0, 8'h03, 32'h0000_1000);
            step();
            set_id(5'd8, 5'd9, 5'd15, 1'b1, 8'h01, 32'h0000_2000);
            step();
            check("rep_count", {16'h0, stall_count}, i + 1);
            check("sat_count", {30'h0, s_count}, (i < 3) ? i + 1 : 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, with integrated load-use hazard detection.
- Captures decoded ID-stage operands, immediate, register specifiers and control bus each cycle.
- Its registered idex_rs/idex_rt/idex_ctrl outputs are what the EX-stage forwarding logic and ALU consume.
- Generates the stall that freezes PC and IF/ID, inserts bubbles on load-use and on flush, and counts hazard stalls for performance reporting.

Parameters:
DATA_W, 32, width of operand/immediate/PC+4 fields
CTRL_W, 8, width of the packed control bus
REGWRITE_BIT, 0, bit index of RegWrite within ctrl
MEMREAD_BIT, 1, bit index of MemRead within ctrl
CNT_W, 16, width of the stall performance counter

Ports:
Clk  input  1  clock, rising-edge
Reset  input  1  synchronous, active-high reset
flush  input  1  squash the ID instruction (taken branch/jump); insert bubble
hold  input  1  global freeze (e.g. memory wait); ID/EX keeps its contents
ifid_rs  input  5  rs of the instruction in ID
ifid_rt  input  5  rt of the instruction in ID
ifid_rd  input  5  rd of the instruction in ID
ifid_uses_rt  input  1  ID instruction reads rt as a source (R-type, store, beq/bne)
id_ctrl  input  CTRL_W  decoded control bus
id_rdata1  input  DATA_W  register file read port 1
id_rdata2  input  DATA_W  register file read port 2
id_imm  input  DATA_W  sign/zero-extended immediate
id_pc4  input  DATA_W  PC+4 of the ID instruction
idex_rs, idex_rt, idex_rd  output  5 each  registered specifiers
idex_ctrl  output  CTRL_W  registered control bus
idex_rdata1, idex_rdata2, idex_imm, idex_pc4  output  DATA_W each  registered data
stall  output  1  combinational; 1 = hold PC and IF/ID this cycle
stall_count  output  CNT_W  number of hazard-bubble cycles, saturating

Behaviour:
- Hazard term: haz = idex_ctrl[MEMREAD_BIT] AND (idex_rt != 0) AND ((idex_rt == ifid_rs) OR (ifid_uses_rt AND idex_rt == ifid_rt)).
- stall = haz AND NOT flush AND NOT hold. Combinational from registered state and ID inputs; no added latency.
- Register update on the rising edge of Clk, in priority order:
  1. Reset: every registered output is 0 and stall_count is 0. After reset, stall is therefore 0.
  2. flush: load a bubble (all registered fields 0, including rs/rt/rd and ctrl). This prevents false forwarding matches and a repeat hazard. stall_count is unchanged.
  3. hold: all registered fields and stall_count keep their values.
  4. haz: load a bubble; stall_count increments by 1, saturating at 2^CNT_W-1 (no wrap).
  5. Otherwise: load all id_*/ifid_* inputs (ifid_uses_rt is not stored).
- One stall cycle per load-use. The bubble clears MemRead, so haz deasserts the next cycle and the held ID instruction then enters EX. The dependent value is then forwarded from MEM/WB.
- Back-to-back load then dependent: exactly one bubble. Load followed by an independent instruction: no bubble.
- A load targeting $0 never stalls.
- Reset while a stall is in progress: reset wins; no bubble is counted that cycle.
- flush and haz in the same cycle: flush wins; no count; stall=0 so IF can redirect.
- Data-path latency ID to EX: 1 cycle. No combinational path from id_* to idex_* outputs.

Test Plan:
- Reset asserted 2 cycles with nonzero inputs -> all idex_* = 0, stall = 0, stall_count = 0; first normal edge after release loads inputs (id_rdata1 = 0x1234_5678 appears on idex_rdata1).
- lw $8 in EX (ctrl MemRead=1, idex_rt=8), ID add with ifid_rs=8 -> stall=1 for exactly one cycle; next idex_ctrl = 0, idex_rs = 0; following edge loads the add; stall_count = 1.
- lw $8 in EX, ID sw with ifid_rt=8, ifid_uses_rt=1 -> stall; same case with ifid_uses_rt=0 (addi writing rt=8) -> no stall, count unchanged.
- lw $0 in EX with ifid_rs=0 -> stall = 0, no bubble.
- flush=1 coincident with load-use hazard -> bubble loaded, stall=0, stall_count unchanged; hold=1 for 3 cycles -> idex_* and count frozen.
- Preload stall_count to 0xFFFE via 0xFFFE hazard cycles (or a bench force), then 3 further hazards -> count reads 0xFFFF and stays there.
